// File: rtl/mmu_param_store.sv
// mmu_param_store
//   Parameter-memory responder for the back-propagation engine's MMU request
//   interface. Two internal synchronous RAMs hold 16-bit weights and biases.
//   The block services one read or write per request. The acknowledge arrives
//   two cycles after the request is accepted, and unmapped addresses are
//   flagged. After reset, or when clear_i is asserted, a sequential sweep
//   zero-fills both arrays before any traffic is accepted.
//
//   Optional feature macro: PARAM_STORE_SAT_EN
//     defined   : write data saturates to [-32768, 32767]; clipping sets sat_o
//     undefined : write data is truncated to mmu_dat_i[15:0]; sat_o stays 0
//
// Ports
//   clk        clock
//   rst        asynchronous active-high reset
//   mmu_req_i  request valid (sampled in IDLE only)
//   mmu_we_i   1 = write, 0 = read
//   mmu_adr_i  32-bit byte address
//   mmu_dat_i  32-bit signed write data
//   mmu_dat_o  read data (sign-extended entry); 0 for writes and errors
//   mmu_ack_o  one-cycle response strobe
//   mmu_err_o  unmapped-address flag, valid with ack
//   clear_i    start zero-fill sweep
//   busy_o     clear sweep in progress
//   sat_o      sticky saturation flag
//
// States
//   state  | meaning
//   CLEAR  | zero-fill sweep, idx = 0..CLR_LEN-1
//   IDLE   | wait for clear_i or mmu_req_i, capture request
//   ACCESS | decode captured address, drive RAM read/write
//   RESP   | register ack/err/data for the response cycle
module mmu_param_store #(
  parameter logic [15:0] WEIGHTS_BASE = 16'h0100,
  parameter logic [15:0] BIASES_BASE  = 16'h0200,
  parameter int          W_DEPTH      = 256,
  parameter int          B_DEPTH      = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mmu_req_i,
  input  logic        mmu_we_i,
  input  logic [31:0] mmu_adr_i,
  input  logic [31:0] mmu_dat_i,
  output logic [31:0] mmu_dat_o,
  output logic        mmu_ack_o,
  output logic        mmu_err_o,
  input  logic        clear_i,
  output logic        busy_o,
  output logic        sat_o
);

  localparam int         CLR_LEN  = (W_DEPTH > B_DEPTH) ? W_DEPTH : B_DEPTH;
  localparam int         WA       = (W_DEPTH > 1) ? $clog2(W_DEPTH) : 1;
  localparam int         BA       = (B_DEPTH > 1) ? $clog2(B_DEPTH) : 1;
  localparam logic [7:0] IDX_LAST = 8'(CLR_LEN - 1);

  typedef enum logic [1:0] {CLEAR, IDLE, ACCESS, RESP} state_t;

  state_t      state;
  logic [7:0]  idx;

  logic        cap_we;
  logic [31:0] cap_adr;
  logic [15:0] cap_wd;
  logic        cap_clip;

  logic        rsp_err;
  logic        rsp_rd;
  logic        rsp_sel_b;

  logic [15:0] conv_wd;
  logic        conv_clip;

  logic        hit_w;
  logic        hit_b;
  logic        hit_any;

  logic [15:0] w_mem [W_DEPTH];
  logic [15:0] b_mem [B_DEPTH];
  logic [15:0] w_q;
  logic [15:0] b_q;
  logic        w_we, w_re, b_we, b_re;
  logic [WA-1:0] w_addr;
  logic [BA-1:0] b_addr;
  logic [15:0] w_wd, b_wd;
  logic [15:0] rd_q;

  // Write-data conversion, applied at capture so only 16 bits are stored.
`ifdef PARAM_STORE_SAT_EN
  always_comb begin
    conv_wd   = mmu_dat_i[15:0];
    conv_clip = 1'b0;
    if ($signed(mmu_dat_i) > 32'sd32767) begin
      conv_wd   = 16'h7FFF;
      conv_clip = 1'b1;
    end else if ($signed(mmu_dat_i) < -32'sd32768) begin
      conv_wd   = 16'h8000;
      conv_clip = 1'b1;
    end
  end
`else
  assign conv_wd   = mmu_dat_i[15:0];
  assign conv_clip = 1'b0;
  // Upper data bits have no effect when truncating.
  logic unused_dat_hi;
  assign unused_dat_hi = ^mmu_dat_i[31:16];
`endif

  // Region decode on the captured address: the page must match the base page
  // exactly and the index must lie inside the configured depth.
  assign hit_w   = (cap_adr[31:8] == {16'h0, WEIGHTS_BASE[15:8]}) &&
                   ({1'b0, cap_adr[7:0]} < 9'(W_DEPTH));
  assign hit_b   = (cap_adr[31:8] == {16'h0, BIASES_BASE[15:8]}) &&
                   ({1'b0, cap_adr[7:0]} < 9'(B_DEPTH));
  assign hit_any = hit_w || hit_b;

  // RAM port control: the sweep owns the ports in CLEAR, the captured request
  // owns them in ACCESS. Weights take priority if both regions ever overlap.
  always_comb begin
    w_we   = 1'b0;
    w_re   = 1'b0;
    w_addr = cap_adr[WA-1:0];
    w_wd   = cap_wd;
    b_we   = 1'b0;
    b_re   = 1'b0;
    b_addr = cap_adr[BA-1:0];
    b_wd   = cap_wd;
    if (state == CLEAR) begin
      w_we   = ({1'b0, idx} < 9'(W_DEPTH));
      w_addr = idx[WA-1:0];
      w_wd   = 16'h0000;
      b_we   = ({1'b0, idx} < 9'(B_DEPTH));
      b_addr = idx[BA-1:0];
      b_wd   = 16'h0000;
    end else if (state == ACCESS) begin
      if (hit_w) begin
        w_we = cap_we;
        w_re = !cap_we;
      end else if (hit_b) begin
        b_we = cap_we;
        b_re = !cap_we;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) w_mem[w_addr] <= w_wd;
    if (w_re) w_q <= w_mem[w_addr];
  end

  always_ff @(posedge clk) begin
    if (b_we) b_mem[b_addr] <= b_wd;
    if (b_re) b_q <= b_mem[b_addr];
  end

  assign rd_q = rsp_sel_b ? b_q : w_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLEAR;
      idx       <= 8'd0;
      busy_o    <= 1'b1;
      mmu_ack_o <= 1'b0;
      mmu_err_o <= 1'b0;
      mmu_dat_o <= 32'h0;
      sat_o     <= 1'b0;
      cap_we    <= 1'b0;
      cap_adr   <= 32'h0;
      cap_wd    <= 16'h0;
      cap_clip  <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rd    <= 1'b0;
      rsp_sel_b <= 1'b0;
    end else begin
      mmu_ack_o <= 1'b0;
      mmu_err_o <= 1'b0;
      case (state)
        CLEAR: begin
          if (idx == IDX_LAST) begin
            state  <= IDLE;
            idx    <= 8'd0;
            busy_o <= 1'b0;
          end else begin
            idx <= idx + 8'd1;
          end
        end
        IDLE: begin
          // A simultaneous request is left pending; the initiator holds it.
          if (clear_i) begin
            state     <= CLEAR;
            idx       <= 8'd0;
            busy_o    <= 1'b1;
            sat_o     <= 1'b0;
            mmu_dat_o <= 32'h0;
          end else if (mmu_req_i) begin
            state    <= ACCESS;
            cap_we   <= mmu_we_i;
            cap_adr  <= mmu_adr_i;
            cap_wd   <= conv_wd;
            cap_clip <= conv_clip;
          end
        end
        ACCESS: begin
          state     <= RESP;
          rsp_err   <= !hit_any;
          rsp_rd    <= !cap_we;
          rsp_sel_b <= !hit_w;
          if (cap_we && hit_any && cap_clip) sat_o <= 1'b1;
        end
        RESP: begin
          state     <= IDLE;
          mmu_ack_o <= 1'b1;
          mmu_err_o <= rsp_err;
          if (rsp_err || !rsp_rd) mmu_dat_o <= 32'h0;
          else                    mmu_dat_o <= {{16{rd_q[15]}}, rd_q};
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_param_store.sv
module tb_mmu_param_store;
  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic        clear;

  logic [31:0] dat_o, dat16_o;
  logic        ack_o, ack16_o;
  logic        err_o, err16_o;
  logic        busy_o, busy16_o;
  logic        sat_o, sat16_o;

  int total;
  int bad;

  mmu_param_store dut (
    .clk(clk), .rst(rst), .mmu_req_i(req), .mmu_we_i(we), .mmu_adr_i(adr),
    .mmu_dat_i(wdat), .mmu_dat_o(dat_o), .mmu_ack_o(ack_o), .mmu_err_o(err_o),
    .clear_i(clear), .busy_o(busy_o), .sat_o(sat_o)
  );

  mmu_param_store #(.W_DEPTH(16)) dut16 (
    .clk(clk), .rst(rst), .mmu_req_i(req), .mmu_we_i(we), .mmu_adr_i(adr),
    .mmu_dat_i(wdat), .mmu_dat_o(dat16_o), .mmu_ack_o(ack16_o), .mmu_err_o(err16_o),
    .clear_i(clear), .busy_o(busy16_o), .sat_o(sat16_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One request; checks the fixed two-cycle acknowledge and returns the
  // response of both instances.
  task automatic access(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output logic re,
                        output logic [31:0] rd16, output logic re16);
    @(negedge clk);
    req = 1'b1; we = w; adr = a; wdat = d;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    check1({tag, "_ack_n1"}, ack_o, 1'b0);
    @(posedge clk); #1;
    check1({tag, "_ack_n2"}, ack_o, 1'b1);
    check1({tag, "_ack16_n2"}, ack16_o, 1'b1);
    rd = dat_o; re = err_o; rd16 = dat16_o; re16 = err16_o;
  endtask

  // Counts rising edges until busy_o falls, noting any ack along the way.
  task automatic count_busy(output int n, output logic seen_ack);
    n = 0;
    seen_ack = 1'b0;
    while (busy_o && n < 400) begin
      @(posedge clk); #1;
      n++;
      if (ack_o) seen_ack = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] rd, rd16;
    logic        re, re16, seen;
    int          n;

    total = 0; bad = 0;
    rst = 1'b0; req = 1'b0; we = 1'b0; adr = 32'h0; wdat = 32'h0; clear = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_dat", dat_o, 32'h0);
    check1("rst_ack", ack_o, 1'b0);
    check1("rst_err", err_o, 1'b0);
    check1("rst_busy", busy_o, 1'b1);
    check1("rst_sat", sat_o, 1'b0);
    check1("rst_busy16", busy16_o, 1'b1);

    @(negedge clk); rst = 1'b0;
    count_busy(n, seen);
    check("boot_busy_len", n, 256);
    check1("boot_no_ack", seen, 1'b0);

    access("rd100", 1'b0, 32'h0000_0100, 32'h0, rd, re, rd16, re16);
    check("rd100_dat", rd, 32'h0);
    check1("rd100_err", re, 1'b0);
    access("rd2ff", 1'b0, 32'h0000_02FF, 32'h0, rd, re, rd16, re16);
    check("rd2ff_dat", rd, 32'h0);
    check1("rd2ff_err", re, 1'b0);

    access("wr105", 1'b1, 32'h0000_0105, 32'h0000_1234, rd, re, rd16, re16);
    check("wr105_dat", rd, 32'h0);
    check1("wr105_err", re, 1'b0);
    access("rd105", 1'b0, 32'h0000_0105, 32'h0, rd, re, rd16, re16);
    check("rd105_dat", rd, 32'h0000_1234);
    check("rd105_dat16", rd16, 32'h0000_1234);

    access("wr203", 1'b1, 32'h0000_0203, 32'hFFFF_8001, rd, re, rd16, re16);
    access("rd203", 1'b0, 32'h0000_0203, 32'h0, rd, re, rd16, re16);
    check("rd203_dat", rd, 32'hFFFF_8001);
    check1("rd203_err", re, 1'b0);

    access("rd300", 1'b0, 32'h0000_0300, 32'h0, rd, re, rd16, re16);
    check1("rd300_err", re, 1'b1);
    check("rd300_dat", rd, 32'h0);
    access("rdhi", 1'b0, 32'h0001_0100, 32'h0, rd, re, rd16, re16);
    check1("rdhi_err", re, 1'b1);
    check("rdhi_dat", rd, 32'h0);
    access("wr300", 1'b1, 32'h0000_0300, 32'h0000_5555, rd, re, rd16, re16);
    check1("wr300_err", re, 1'b1);
    check("wr300_dat", rd, 32'h0);
    access("rb105", 1'b0, 32'h0000_0105, 32'h0, rd, re, rd16, re16);
    check("rb105_dat", rd, 32'h0000_1234);
    access("rb203", 1'b0, 32'h0000_0203, 32'h0, rd, re, rd16, re16);
    check("rb203_dat", rd, 32'hFFFF_8001);
    access("rb100", 1'b0, 32'h0000_0100, 32'h0, rd, re, rd16, re16);
    check("rb100_dat", rd, 32'h0);

    access("rd110", 1'b0, 32'h0000_0110, 32'h0, rd, re, rd16, re16);
    check1("rd110_err256", re, 1'b0);
    check1("rd110_err16", re16, 1'b1);
    check("rd110_dat16", rd16, 32'h0);
    access("rd10f", 1'b0, 32'h0000_010F, 32'h0, rd, re, rd16, re16);
    check1("rd10f_err16", re16, 1'b0);

    access("wr_pos", 1'b1, 32'h0000_0101, 32'h0000_9000, rd, re, rd16, re16);
    access("rd_pos", 1'b0, 32'h0000_0101, 32'h0, rd, re, rd16, re16);
`ifdef PARAM_STORE_SAT_EN
    check("sat_pos_dat", rd, 32'h0000_7FFF);
    check1("sat_pos_flag", sat_o, 1'b1);
`else
    check("trunc_pos_dat", rd, 32'hFFFF_9000);
    check1("trunc_pos_flag", sat_o, 1'b0);
`endif
    access("wr_neg", 1'b1, 32'h0000_0101, 32'hFFFF_0000, rd, re, rd16, re16);
    access("rd_neg", 1'b0, 32'h0000_0101, 32'h0, rd, re, rd16, re16);
`ifdef PARAM_STORE_SAT_EN
    check("sat_neg_dat", rd, 32'hFFFF_8000);
    check1("sat_neg_flag", sat16_o, 1'b1);
`else
    check("trunc_neg_dat", rd, 32'h0000_0000);
    check1("trunc_neg_flag", sat16_o, 1'b0);
`endif

    // Clear and request together: clear wins, request served after the sweep.
    @(negedge clk);
    clear = 1'b1; req = 1'b1; we = 1'b0; adr = 32'h0000_0105; wdat = 32'h0;
    @(posedge clk); #1;
    clear = 1'b0;
    check1("clr_busy_rise", busy_o, 1'b1);
    check1("clr_sat", sat_o, 1'b0);
    count_busy(n, seen);
    check("clr_busy_len", n, 256);
    check1("clr_no_ack", seen, 1'b0);
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    check1("clr_req_ack_n1", ack_o, 1'b0);
    @(posedge clk); #1;
    check1("clr_req_ack", ack_o, 1'b1);
    check("clr_req_dat", dat_o, 32'h0);
    check1("clr_req_err", err_o, 1'b0);

    // Reset in the middle of a write: no ack, sweep restarts.
    @(negedge clk);
    req = 1'b1; we = 1'b1; adr = 32'h0000_0105; wdat = 32'h0000_7777;
    @(posedge clk); #1;
    req = 1'b0; rst = 1'b1;
    #2;
    check1("rstx_ack", ack_o, 1'b0);
    check1("rstx_busy", busy_o, 1'b1);
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    repeat (100) begin
      @(posedge clk); #1;
      if (ack_o) seen = 1'b1;
    end
    check1("rstx_mid_busy", busy_o, 1'b1);
    check1("rstx_no_ack", seen, 1'b0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    count_busy(n, seen);
    check("rsts_busy_len", n, 256);
    check1("rsts_no_ack", seen, 1'b0);
    access("rd_after_rst", 1'b0, 32'h0000_0105, 32'h0, rd, re, rd16, re16);
    check("rd_after_rst_dat", rd, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmu_param_store.md
# mmu_param_store

Parameter-memory responder on the MMU request interface driven by the back-propagation engine. Holds the 16-bit weight and bias arrays in two internal synchronous RAMs, services one read or write per request with a fixed two-cycle acknowledge, and flags unmapped addresses. On reset or on command it zero-fills both arrays with a sequential clear sweep before accepting traffic.

## Interface
Parameters:
- WEIGHTS_BASE, 16'h0100, base address of weight region (low 8 bits must be 0)
- BIASES_BASE, 16'h0200, base address of bias region (low 8 bits must be 0)
- W_DEPTH, 256, weight entries (1..256)
- B_DEPTH, 256, bias entries (1..256)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- mmu_req_i  in  1  request valid
- mmu_we_i  in  1  1 = write, 0 = read
- mmu_adr_i  in  32  byte address
- mmu_dat_i  in  32  write data, signed
- mmu_dat_o  out  32  read data, sign-extended 16-bit entry
- mmu_ack_o  out  1  one-cycle response strobe
- mmu_err_o  out  1  unmapped-address flag, valid with ack
- clear_i  in  1  start zero-fill sweep
- busy_o  out  1  clear sweep in progress; requests not accepted
- sat_o  out  1  sticky: a write was saturated (macro-dependent)

## Operation
- States: CLEAR, IDLE, ACCESS, RESP.
- CLEAR: counter idx runs 0..CLR_LEN-1, CLR_LEN = max(W_DEPTH, B_DEPTH); each cycle writes 0 to weight[idx] if idx < W_DEPTH and bias[idx] if idx < B_DEPTH. After idx = CLR_LEN-1 -> IDLE. sat_o cleared on entry.
- IDLE: clear_i=1 -> CLEAR (idx=0). Else mmu_req_i=1 -> capture we, adr, dat -> ACCESS. clear_i and mmu_req_i together: clear wins; request not captured (initiator holds req, accepted after sweep).
- Decode: adr[31:8] == {16'h0, BASE[15:8]} selects region; index = adr[7:0]. Hit requires index < region depth. Anything else is unmapped.
- ACCESS: mapped write -> RAM write; mapped read -> RAM read issued; unmapped -> no RAM access. -> RESP.
- RESP: mmu_ack_o=1 one cycle; read data on mmu_dat_o = {{16{q[15]}}, q}; unmapped: mmu_err_o=1, mmu_dat_o=0, writes discarded. Write response: mmu_dat_o=0. -> IDLE.
- mmu_dat_o holds its value until the next RESP or a clear; mmu_err_o is low outside RESP.
- Write data conversion: see Configuration.
- mmu_req_i sampled only in IDLE; a request held high through RESP is taken as a new request in the following IDLE cycle.

## Timing
- Reset values: mmu_dat_o=0, mmu_ack_o=0, mmu_err_o=0, busy_o=1, sat_o=0; state=CLEAR, idx=0.
- After reset release, busy_o stays 1 for exactly CLR_LEN rising edges, then 0. A clear_i-initiated sweep asserts busy_o one cycle after clear_i is sampled, for CLR_LEN cycles.
- Latency: req sampled at edge N -> ack high in cycle following edge N+2; next request sampled at edge N+3 earliest. Throughput 1 access per 3 cycles.
- Read after write: a read accepted after the write's ack returns the new value.
- Reset mid-transaction or mid-sweep: in-flight access is dropped, no ack issued, sweep restarts at idx=0.

## Configuration
- PARAM_STORE_SAT_EN defined: writes saturate signed 32-bit mmu_dat_i to 16-bit range [-32768, 32767]; any clipped write sets sat_o (sticky until next clear or reset).
- Undefined: writes store mmu_dat_i[15:0] (truncation); sat_o tied 0.

## Test plan
- Reset, W_DEPTH=B_DEPTH=256 -> busy_o high exactly 256 cycles; read 0x0100 and 0x02FF -> mmu_dat_o=0, err=0.
- Write 0x0000_0105 data 0x0000_1234, then read 0x0105 -> ack 2 cycles after each accept, read returns 0x0000_1234; write 0x0203 data 0xFFFF_8001, read -> 0xFFFF_8001.
- Read 0x0000_0300 and 0x0001_0100 -> ack with err=1, dat=0; write to 0x0300 leaves all arrays unchanged.
- W_DEPTH=16: read 0x0110 -> err=1; read 0x010F -> err=0.
- With PARAM_STORE_SAT_EN: write 0x0000_9000 to 0x0101 -> read 0x0000_7FFF, sat_o=1; write 0xFFFF_0000 -> read 0xFFFF_8000. Without macro: same writes read 0xFFFF_9000 and 0x0000_0000, sat_o=0.
- clear_i and mmu_req_i asserted same cycle in IDLE after populating data -> sweep runs, request acked only after busy_o falls, read returns 0; rst pulsed mid-sweep -> busy_o restarts full CLR_LEN count, no ack.
